// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: memory-side responder for the cache line-transfer handshake.
// Serialises a dirty-line write-back, or a line refill, into 32-bit word beats
// on a req/ack memory port. It pulses save_ready when a write-back completes.
// It pulses load_enable, with write_load_data valid, when a refill completes.
//
// Optional build macro: CACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
//   defined   -> a refill starts at the word addressed by refill_addr and wraps
//                within the line; every word still lands in its own line slot.
//   undefined -> a refill always starts at word 0.
//
// LINE_BYTES must be a power of two, a multiple of 4, and at least 8.

module cache_mem_bridge #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    save_data,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [LINE_BYTES*8-1:0] write_back_data,
  output logic                    save_ready,
  input  logic                    refill_req,
  input  logic [ADDR_W-1:0]       refill_addr,
  output logic [LINE_BYTES*8-1:0] write_load_data,
  output logic                    load_enable,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack
);

  localparam int NW = LINE_BYTES / 4;   // words per line
  localparam int OB = $clog2(LINE_BYTES); // line offset bits
  localparam int CW = $clog2(NW);         // beat counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_WB_DONE,
    S_RF,
    S_RF_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_W-1:0]     base_q;
  logic [NW-1:0][31:0]   line_q;       // write-back source / refill assembly
  logic [NW-1:0][31:0]   line_merged;  // line_q with the current read beat inserted
  logic [NW-1:0][31:0]   load_q;       // last completed refill line
  logic [CW-1:0]         word_idx;     // line slot addressed by the current beat
  logic                  last_beat;
  logic                  unused_addr_bits;

`ifdef CACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
  logic [CW-1:0]         start_q;      // critical word of the refill in progress
  logic [CW:0]           word_sum;

  // Refill beats rotate from the critical word, wrapping inside the line.
  always_comb begin
    word_sum = {1'b0, start_q} + {1'b0, cnt_q};
    if (state_q == S_RF) begin
      if (word_sum >= (CW+1)'(NW)) word_idx = CW'(word_sum - (CW+1)'(NW));
      else                         word_idx = word_sum[CW-1:0];
    end else begin
      word_idx = cnt_q;
    end
  end

  assign unused_addr_bits = ^{wb_addr[OB-1:0], refill_addr[1:0]};
`else
  assign word_idx         = cnt_q;
  assign unused_addr_bits = ^{wb_addr[OB-1:0], refill_addr[OB-1:0]};
`endif

  assign last_beat       = (cnt_q == CW'(NW - 1));
  assign write_load_data = load_q;

  // Insert the returning read word into its own slot of the line.
  always_comb begin
    line_merged           = line_q;
    line_merged[word_idx] = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every process
    // reading state_q sees the pre-edge value regardless of evaluation order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-state memory port / handshake outputs.
  always_comb begin
    // NOTE: every output receives a default before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    busy        = (state_q != S_IDLE);
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    save_ready  = 1'b0;
    load_enable = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (save_data)       state_d = S_WB;
        else if (refill_req) state_d = S_RF;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_W'({word_idx, 2'b00});
        mem_wdata = line_q[cnt_q];
        if (mem_ack && last_beat) state_d = S_WB_DONE;
      end
      S_WB_DONE: begin
        save_ready = 1'b1;
        state_d    = S_IDLE;
      end
      S_RF: begin
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'({word_idx, 2'b00});
        if (mem_ack && last_beat) state_d = S_RF_DONE;
      end
      S_RF_DONE: begin
        load_enable = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture in IDLE, beat counting, and refill line assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the line buffers are flops, not RAM, and are cleared on reset so
      // a refill abandoned by reset can never leak a partial line.
      cnt_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
      load_q  <= '0;
`ifdef CACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
      start_q <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (save_data) begin
            base_q <= {wb_addr[ADDR_W-1:OB], {OB{1'b0}}};
            line_q <= write_back_data;
          end else if (refill_req) begin
            base_q  <= {refill_addr[ADDR_W-1:OB], {OB{1'b0}}};
            line_q  <= '0;
`ifdef CACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
            start_q <= refill_addr[OB-1:2];
`endif
          end
        end
        S_WB: begin
          if (mem_ack && !last_beat) cnt_q <= cnt_q + 1'b1;
        end
        S_RF: begin
          if (mem_ack) begin
            line_q <= line_merged;
            if (last_beat) load_q <= line_merged;
            else           cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
